// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared constants and types for the crypto instruction sequencer
// Purpose: opcode values, FSM state encoding, instruction field positions and
//          datapath widths used by crypto_seq_ctrl and crypto_regfile.
// Ports:   none (package).
package crypto_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

  // Register-to-register ops whose ALU opcode is the instruction opcode itself.
  function automatic logic is_rr_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/crypto_regfile.sv
// rtl/crypto_regfile.sv - 4 x 8-bit register file, one write port, three read ports
// Purpose: architectural registers R0..R3 for the sequencer.
// Ports:   clk, rst (sync active-high, clears all registers)
//          we, waddr, wdata          - write port, takes effect on the rising edge
//          addr_a/data_a, addr_b/data_b, addr_dbg/data_dbg - combinational reads
module crypto_regfile
  import crypto_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] addr_a,
  input  logic [REG_AW-1:0] addr_b,
  input  logic [REG_AW-1:0] addr_dbg,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] data_dbg
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-write value, so rd==rs operations use the old contents.
  assign data_a   = regs[addr_a];
  assign data_b   = regs[addr_b];
  assign data_dbg = regs[addr_dbg];

endmodule

// File: rtl/crypto_seq_ctrl.sv
// rtl/crypto_seq_ctrl.sv - fetch/decode/execute sequencer for the 8-bit crypto ALU
// Purpose: runs a program from imem address 0 until HALT, driving an external
//          combinational ALU and writing results back to a 4-entry register file.
// Ports:   clk, rst (sync active-high)
//          start            - one-cycle pulse, honoured only while idle
//          busy, done       - busy outside IDLE; done pulses once when HALT retires
//          illegal          - sticky undefined-opcode flag, cleared by start/rst
//          imem_addr/imem_data - synchronous instruction memory (one-cycle read)
//          alu_enable/alu_opcode/alu_a/alu_b/alu_result - ALU interface
//          dbg_sel/dbg_data - combinational register readout
module crypto_seq_ctrl
  import crypto_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int NREGS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_data,
  output logic               alu_enable,
  output logic [3:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t             state, state_nxt;
  logic [IMEM_AW-1:0] pc, pc_nxt;
  logic [15:0]        ir;
  logic               done_nxt;
  logic               illegal_nxt;
  logic               rf_we;

  logic [3:0]         op;
  logic [REG_AW-1:0]  rd, rs;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  rd_val, rs_val;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  crypto_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (alu_result),
    .addr_a   (rd),
    .addr_b   (rs),
    .addr_dbg (dbg_sel),
    .data_a   (rd_val),
    .data_b   (rs_val),
    .data_dbg (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      done    <= done_nxt;
      illegal <= illegal_nxt;
      if (state == DECODE) begin
        ir <= imem_data;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    done_nxt    = 1'b0;
    illegal_nxt = illegal;
    rf_we       = 1'b0;
    alu_enable  = 1'b0;
    alu_opcode  = '0;
    alu_a       = '0;
    alu_b       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          pc_nxt      = '0;
          illegal_nxt = 1'b0;
          state_nxt   = FETCH;
        end
      end
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc + IMEM_AW'(1);
        if (is_rr_op(op)) begin
          alu_enable = 1'b1;
          alu_opcode = op;
          alu_a      = rd_val;
          alu_b      = rs_val;
          rf_we      = 1'b1;
        end else if (op == OP_LDI) begin
          // LDI reuses the ALU's MOV path with the immediate as operand b.
          alu_enable = 1'b1;
          alu_opcode = OP_MOV;
          alu_a      = rd_val;
          alu_b      = imm;
          rf_we      = 1'b1;
        end else if (op == OP_HALT) begin
          state_nxt = IDLE;
          pc_nxt    = pc;
          done_nxt  = 1'b1;
        end else if (op != OP_NOP) begin
          illegal_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  // The synchronous memory registers its address every cycle; pc only moves
  // in EXEC, so presenting pc continuously gives the FETCH address.
  assign imem_addr = pc;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// tb/tb_crypto_seq_ctrl.sv - scoreboard testbench for crypto_seq_ctrl
module tb_crypto_seq_ctrl;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, XOR = 4'h3;
  localparam logic [3:0] MOV = 4'h4, LDI = 4'h5, HLT = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, illegal;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        alu_enable;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          start_edge = 0;
  int          tests = 0;
  int          fails = 0;
  int          phase = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_exp_t;

  typedef struct packed {
    logic [31:0]     lat;
    logic            ill;
    logic [3:0][7:0] r;
  } done_exp_t;

  alu_exp_t        exp_alu[$];
  done_exp_t       exp_done[$];
  logic [7:0]      exp_addr[$];
  logic [3:0][7:0] exp_snap[$];

  crypto_seq_ctrl #(.IMEM_AW(8), .NREGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    imem_data <= mem[imem_addr];
  end

  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      4'h1: alu_result = alu_a + alu_b;
      4'h2: alu_result = alu_a - alu_b;
      4'h3: alu_result = alu_a ^ alu_b;
      4'h4: alu_result = alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: DUT output with empty scoreboard queue", nm);
  endfunction

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Monitor: the only process that drives dbg_sel.
  always @(negedge clk) begin
    alu_exp_t        ea;
    done_exp_t       ed;
    logic [3:0][7:0] es;
    if (busy) begin
      if (phase == 0) begin
        if (exp_addr.size() == 0) unexpected("fetch_addr");
        else chk("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_addr.pop_front()});
      end
      phase = (phase + 1) % 3;
    end else begin
      phase = 0;
    end
    if (alu_enable) begin
      if (exp_alu.size() == 0) unexpected("alu_enable");
      else begin
        ea = exp_alu.pop_front();
        chk("alu_opcode", {28'h0, alu_opcode}, {28'h0, ea.op});
        chk("alu_a", {24'h0, alu_a}, {24'h0, ea.a});
        chk("alu_b", {24'h0, alu_b}, {24'h0, ea.b});
      end
    end
    if (done) begin
      if (exp_done.size() == 0) unexpected("done");
      else begin
        ed = exp_done.pop_front();
        chk("done_latency", cyc - start_edge, ed.lat);
        chk("done_illegal", {31'h0, illegal}, {31'h0, ed.ill});
        for (int i = 0; i < 4; i++) begin
          dbg_sel = i[1:0];
          #1;
          chk($sformatf("done_r%0d", i), {24'h0, dbg_data}, {24'h0, ed.r[i]});
        end
      end
    end else if (exp_snap.size() != 0) begin
      es = exp_snap.pop_front();
      for (int i = 0; i < 4; i++) begin
        dbg_sel = i[1:0];
        #1;
        chk($sformatf("snap_r%0d", i), {24'h0, dbg_data}, {24'h0, es[i]});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc(NOP, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    if (busy) chk("wait_idle_timeout", 32'h1, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic push_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_alu.push_back('{op: op, a: a, b: b});
  endtask

  task automatic push_done(input int lat, input logic ill, input logic [3:0][7:0] r);
    exp_done.push_back('{lat: lat, ill: ill, r: r});
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(i[7:0]);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_alu_ctrl", {19'h0, alu_enable, alu_opcode, alu_a}, 32'h0);
    chk("rst_alu_b", {24'h0, alu_b}, 32'h0);
    exp_snap.push_back({8'h00, 8'h00, 8'h00, 8'h00});
    repeat (2) @(posedge clk);

    // LDI/LDI/XOR/HALT
    clear_mem();
    mem[0] = enc(LDI, 2'd0, 2'd0, 8'h3C);
    mem[1] = enc(LDI, 2'd1, 2'd0, 8'h0F);
    mem[2] = enc(XOR, 2'd0, 2'd1, 8'h00);
    mem[3] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(4);
    push_alu(4'h4, 8'h00, 8'h3C);
    push_alu(4'h4, 8'h00, 8'h0F);
    push_alu(4'h3, 8'h3C, 8'h0F);
    push_done(12, 1'b0, {8'h00, 8'h00, 8'h0F, 8'h33});
    do_start();
    wait_idle(100);
    chk("t1_busy_after", {31'h0, busy}, 32'h0);

    // modulo-256 add and rd==rs subtract
    clear_mem();
    mem[0] = enc(LDI, 2'd2, 2'd0, 8'hFF);
    mem[1] = enc(LDI, 2'd3, 2'd0, 8'h01);
    mem[2] = enc(ADD, 2'd2, 2'd3, 8'h00);
    mem[3] = enc(SUB, 2'd3, 2'd3, 8'h00);
    mem[4] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(5);
    push_alu(4'h4, 8'h00, 8'hFF);
    push_alu(4'h4, 8'h00, 8'h01);
    push_alu(4'h1, 8'hFF, 8'h01);
    push_alu(4'h2, 8'h01, 8'h01);
    push_done(15, 1'b0, {8'h00, 8'h00, 8'h0F, 8'h33});
    do_start();
    wait_idle(100);

    // illegal opcode, then a fresh start clears the flag
    clear_mem();
    mem[0] = enc(4'h7, 2'd1, 2'd2, 8'h5A);
    mem[1] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(2);
    push_done(6, 1'b1, {8'h00, 8'h00, 8'h0F, 8'h33});
    do_start();
    wait_idle(100);
    chk("t3_illegal_sticky", {31'h0, illegal}, 32'h1);
    mem[0] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(1);
    push_done(3, 1'b0, {8'h00, 8'h00, 8'h0F, 8'h33});
    do_start();
    chk("t3_illegal_cleared", {31'h0, illegal}, 32'h0);
    wait_idle(100);

    // second start while busy is ignored
    clear_mem();
    mem[0] = enc(LDI, 2'd1, 2'd0, 8'hA5);
    mem[1] = enc(MOV, 2'd2, 2'd1, 8'h00);
    mem[2] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(3);
    push_alu(4'h4, 8'h0F, 8'hA5);
    push_alu(4'h4, 8'h00, 8'hA5);
    push_done(9, 1'b0, {8'h00, 8'hA5, 8'hA5, 8'h33});
    do_start();
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(100);

    // reset during EXEC of the second instruction
    clear_mem();
    mem[0] = enc(LDI, 2'd0, 2'd0, 8'h11);
    mem[1] = enc(LDI, 2'd3, 2'd0, 8'h22);
    mem[2] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(2);
    push_alu(4'h4, 8'h33, 8'h11);
    push_alu(4'h4, 8'h00, 8'h22);
    do_start();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy_after_rst", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    exp_snap.push_back({8'h00, 8'h00, 8'h00, 8'h00});
    repeat (6) @(posedge clk);
    chk("t5_no_done", {31'h0, busy}, 32'h0);

    // NOPs with HALT at 0x02
    clear_mem();
    mem[2] = enc(HLT, 2'd0, 2'd0, 8'h00);
    push_addrs(3);
    push_done(9, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00});
    do_start();
    wait_idle(100);

    // PC wrap: 256 NOPs, then HALT found at address 0 again
    clear_mem();
    push_addrs(256);
    exp_addr.push_back(8'h00);
    push_done(771, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00});
    do_start();
    @(posedge clk);
    #1;
    mem[0] = enc(HLT, 2'd0, 2'd0, 8'h00);
    wait_idle(1000);
    chk("wrap_final_addr", {24'h0, imem_addr}, 32'h0);

    chk("alu_q_empty", exp_alu.size(), 32'h0);
    chk("done_q_empty", exp_done.size(), 32'h0);
    chk("addr_q_empty", exp_addr.size(), 32'h0);
    chk("snap_q_empty", exp_snap.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
